// File: rtl/result_checker.sv
// result_checker: compares DUT result words against an expected-result FIFO.
// Optional CHECKER_STOP_ON_FAIL_EN: halt the run on the first failed compare.
`timescale 1ns/1ps
module result_checker #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] num_blocks,
  input  logic             dut_valid,
  input  logic [127:0]     dut_result,
  output logic             dut_ready,
  output logic             exp_require,
  input  logic [127:0]     exp_data,
  input  logic             exp_empty,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic             mismatch,
  output logic [127:0]     first_fail_exp,
  output logic [127:0]     first_fail_got,
  output logic [CNT_W-1:0] first_fail_idx,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2,
    HALT = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] ONE =
    {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W:0] ONE_X =
    {{CNT_W{1'b0}}, 1'b1};

  state_t           state;
  logic             accept;
  logic             hit;
  logic             last;
  logic [CNT_W:0]   total;
  logic [CNT_W:0]   total_nx;
  logic [CNT_W-1:0] idx;

  assign dut_ready   = (state == RUN) & ~exp_empty
                     & ~abort & ~rst;
  assign accept      = dut_valid & dut_ready;
  assign exp_require = accept;
  assign hit         = (dut_result == exp_data);

  assign total    = {1'b0, pass_cnt} + {1'b0, fail_cnt};
  assign total_nx = total + ONE_X;
  assign idx      = total[CNT_W] ? '1 : total[CNT_W-1:0];
  assign last     = (num_blocks != '0) &&
                    (total_nx == {1'b0, num_blocks});

  assign busy = (state == RUN) || (state == HALT);
  assign done = (state == DONE);

  // Run control, saturating compare counters and first-failure capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      pass_cnt       <= '0;
      fail_cnt       <= '0;
      mismatch       <= 1'b0;
      first_fail_exp <= '0;
      first_fail_got <= '0;
      first_fail_idx <= '0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (start && !abort) begin
            state          <= RUN;
            pass_cnt       <= '0;
            fail_cnt       <= '0;
            mismatch       <= 1'b0;
            first_fail_exp <= '0;
            first_fail_got <= '0;
            first_fail_idx <= '0;
          end
        end
        RUN: begin
          if (abort) begin
            state <= DONE;
          end else if (accept) begin
            if (hit) begin
              if (pass_cnt != '1)
                pass_cnt <= pass_cnt + ONE;
            end else begin
              if (fail_cnt != '1)
                fail_cnt <= fail_cnt + ONE;
              if (!mismatch) begin
                mismatch       <= 1'b1;
                first_fail_exp <= exp_data;
                first_fail_got <= dut_result;
                first_fail_idx <= idx;
              end
            end
            if (last) begin
              state <= DONE;
            end
`ifdef CHECKER_STOP_ON_FAIL_EN
            else if (!hit && !mismatch) begin
              state <= HALT;
            end
`endif
          end
        end
        HALT: begin
          if (abort)
            state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_result_checker.sv
// tb_result_checker: randomized scoreboard bench for result_checker.
// Expected compare outcomes queue at stimulus time; a monitor retires them.
`timescale 1ns/1ps
module tb_result_checker;

  localparam int W = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst = 1'b1;
  logic           start = 1'b0;
  logic           abort = 1'b0;
  logic [W-1:0]   num_blocks = '0;
  logic           dut_valid = 1'b0;
  logic [127:0]   dut_result = '0;
  logic [127:0]   exp_data = '0;
  logic           exp_empty = 1'b1;
  logic           dut_ready, exp_require;
  logic           mismatch, busy, done;
  logic [W-1:0]   pass_cnt, fail_cnt, first_fail_idx;
  logic [127:0]   first_fail_exp, first_fail_got;

  result_checker #(.CNT_W(W)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .num_blocks(num_blocks),
    .dut_valid(dut_valid), .dut_result(dut_result),
    .dut_ready(dut_ready), .exp_require(exp_require),
    .exp_data(exp_data), .exp_empty(exp_empty),
    .pass_cnt(pass_cnt), .fail_cnt(fail_cnt),
    .mismatch(mismatch),
    .first_fail_exp(first_fail_exp),
    .first_fail_got(first_fail_got),
    .first_fail_idx(first_fail_idx),
    .busy(busy), .done(done)
  );

  typedef struct {
    logic [127:0] e;
    logic [127:0] g;
  } pair_t;

  logic [127:0] eq[$];
  logic [127:0] dq[$];
  pair_t        sb[$];

  int checks = 0;
  int errors = 0;
  int pops = 0;
  int stall_pct = 0;
  int gap_pct = 0;
  bit hold_exp = 0;
  bit acc_prev = 0;

  bit           m_run = 0, m_halt = 0, m_done = 0, m_mm = 0;
  logic [W-1:0] m_pass = '0, m_fail = '0, m_idx = '0;
  logic [127:0] m_fe = '0, m_fg = '0;

  task automatic chk(input string n, input logic [127:0] got,
                     input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", n, got, exp);
    end
  endtask

  task automatic push(input logic [127:0] e, input logic [127:0] g);
    pair_t p;
    p.e = e;
    p.g = g;
    eq.push_back(e);
    dq.push_back(g);
    sb.push_back(p);
  endtask

  task automatic flush();
    eq.delete();
    dq.delete();
    sb.delete();
    acc_prev = 0;
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic tick(input bit s = 1'b0, input bit a = 1'b0,
                      input bit r = 1'b0);
    @(negedge clk);
    if (acc_prev) begin
      if (eq.size() > 0) void'(eq.pop_front());
      if (dq.size() > 0) void'(dq.pop_front());
      acc_prev = 0;
    end
    start = s;
    abort = a;
    rst   = r;
    exp_empty = hold_exp || (eq.size() == 0) ||
                ($urandom_range(99) < gap_pct);
    exp_data = '0;
    if (eq.size() > 0) exp_data = eq[0];
    dut_result = '0;
    dut_valid  = 1'b0;
    if (dq.size() > 0) begin
      dut_result = dq[0];
      dut_valid  = ($urandom_range(99) >= stall_pct);
    end
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget; i++) begin
      tick();
      #3;
      if (done === 1'b1) return;
    end
    checks++;
    errors++;
    $display("FAIL wait_done timeout got=%0b exp=1", done);
  endtask

  task automatic wait_pops(input int target, input int budget);
    for (int i = 0; i < budget; i++) begin
      tick();
      #3;
      if (pops >= target) return;
    end
    checks++;
    errors++;
    $display("FAIL wait_pops timeout got=%0d exp=%0d", pops, target);
  endtask

  // Monitor: checks outputs against the model, then retires accepts.
  initial begin
    pair_t p;
    bit    rdy;
    bit    first;
    forever begin
      @(negedge clk);
      #2;
      chk("pass_cnt", pass_cnt, m_pass);
      chk("fail_cnt", fail_cnt, m_fail);
      chk("busy", busy, m_run | m_halt);
      chk("done", done, m_done);
      chk("mismatch", mismatch, m_mm);
      chk("ff_idx", first_fail_idx, m_idx);
      chk("ff_exp", first_fail_exp, m_fe);
      chk("ff_got", first_fail_got, m_fg);
      rdy = m_run && !exp_empty && !abort && !rst;
      chk("dut_ready", dut_ready, rdy);
      chk("exp_require", exp_require, rdy && dut_valid);
      acc_prev = (exp_require === 1'b1);
      if (acc_prev) pops++;
      if (rst) begin
        m_run = 0; m_halt = 0; m_done = 0; m_mm = 0;
        m_pass = '0; m_fail = '0; m_idx = '0;
        m_fe = '0; m_fg = '0;
      end else if (m_run) begin
        if (abort) begin
          m_run = 0;
          m_done = 1;
        end else if (rdy && dut_valid) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_empty got=pop exp=none");
          end else begin
            p = sb.pop_front();
            first = 0;
            if (p.e == p.g) begin
              if (m_pass != '1) m_pass++;
            end else begin
              if (!m_mm) begin
                first = 1;
                m_mm = 1;
                m_fe = p.e;
                m_fg = p.g;
                m_idx = m_pass + m_fail;
              end
              if (m_fail != '1) m_fail++;
            end
            if (num_blocks != 0 && m_pass + m_fail == num_blocks) begin
              m_run = 0;
              m_done = 1;
            end
`ifdef CHECKER_STOP_ON_FAIL_EN
            else if (first) begin
              m_run = 0;
              m_halt = 1;
            end
`endif
          end
        end
      end else if (m_halt) begin
        if (abort) begin
          m_halt = 0;
          m_done = 1;
        end
      end else if (start && !abort) begin
        m_run = 1; m_done = 0; m_mm = 0;
        m_pass = '0; m_fail = '0; m_idx = '0;
        m_fe = '0; m_fg = '0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    logic [127:0] w, one;
    one = 128'd1;

    tick(0, 0, 1);
    tick(0, 0, 1);
    tick();
    tick();
    #3;
    chk("rst_pass", pass_cnt, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);

    // four matching words, bounded run
    num_blocks = 4;
    stall_pct = 30;
    for (int i = 1; i <= 4; i++) push(i, i);
    base = pops;
    tick(1);
    wait_done(100);
    tick();
    #3;
    chk("a_pass", pass_cnt, 4);
    chk("a_fail", fail_cnt, 0);
    chk("a_done", done, 1);
    chk("a_pops", pops - base, 4);
    flush();

    // single-bit failure on block 1
    num_blocks = 3;
    w = rnd128(); push(w, w);
    w = rnd128(); push(w, w ^ one);
    w = rnd128(); push(w, w);
    tick(1);
    wait_done(100);
    tick();
    #3;
    chk("b_pass", pass_cnt, 2);
    chk("b_fail", fail_cnt, 1);
    chk("b_idx", first_fail_idx, 1);
    chk("b_xor", first_fail_got ^ first_fail_exp, 1);
    chk("b_mm", mismatch, 1);
    flush();

    // expected FIFO empty while DUT words are valid
    num_blocks = 0;
    stall_pct = 0;
    hold_exp = 1;
    push(rnd128(), rnd128());
    push(rnd128(), rnd128());
    base = pops;
    tick(1);
    for (int i = 0; i < 5; i++) begin
      tick();
      #1;
      chk("c_valid_stim", dut_valid, 1);
      chk("c_ready", dut_ready, 0);
      chk("c_req", exp_require, 0);
    end
    #2;
    chk("c_pass", pass_cnt, 0);
    chk("c_fail", fail_cnt, 0);
    chk("c_pops", pops - base, 0);
    chk("c_busy", busy, 1);
    tick(0, 1);
    tick();
    #3;
    chk("c_abort_done", done, 1);
    hold_exp = 0;
    flush();

    // reset in the same cycle as the accept of block 2
    for (int i = 0; i < 5; i++) begin
      w = rnd128();
      push(w, w);
    end
    base = pops;
    tick(1);
    wait_pops(base + 2, 50);
    tick(0, 0, 1);
    #1;
    chk("d_req_in_rst", exp_require, 0);
    #2;
    tick();
    #3;
    chk("d_pass", pass_cnt, 0);
    chk("d_fail", fail_cnt, 0);
    chk("d_busy", busy, 0);
    chk("d_done", done, 0);
    chk("d_pops", pops - base, 2);
    flush();

    // unbounded run, 20 words, abort, then restart clears
    stall_pct = 40;
    for (int i = 0; i < 20; i++) begin
      w = rnd128();
      push(w, w);
    end
    base = pops;
    tick(1);
    wait_pops(base + 20, 300);
    tick(0, 1);
    tick();
    #3;
    chk("e_pass", pass_cnt, 20);
    chk("e_done", done, 1);
    tick(1);
    tick();
    #3;
    chk("e_clr_pass", pass_cnt, 0);
    chk("e_clr_fail", fail_cnt, 0);
    chk("e_busy", busy, 1);
    tick(0, 1);
    tick();
    #3;
    flush();

    // randomized bounded runs with corruption, gaps and stray starts
    for (int r = 0; r < 6; r++) begin
      int nb;
      nb = $urandom_range(12, 3);
      num_blocks = nb;
      stall_pct = $urandom_range(50);
      gap_pct = $urandom_range(30);
      for (int i = 0; i < nb + 3; i++) begin
        w = rnd128();
        if ($urandom_range(3) == 0)
          push(w, w ^ (one << $urandom_range(127)));
        else
          push(w, w);
      end
      tick(1);
      tick();
      tick(1);
      wait_done(400);
      tick();
      tick(1, 1);
      tick();
      #3;
      chk("f_hold_done", done, 1);
      chk("f_total", pass_cnt + fail_cnt, nb);
      flush();
    end
    gap_pct = 0;
    stall_pct = 0;

`ifdef CHECKER_STOP_ON_FAIL_EN
    num_blocks = 0;
    w = rnd128();
    push(w, w ^ 128'd4);
    for (int i = 0; i < 3; i++) begin
      w = rnd128();
      push(w, w);
    end
    base = pops;
    tick(1);
    for (int i = 0; i < 10; i++) tick();
    #1;
    chk("g_ready", dut_ready, 0);
    #2;
    chk("g_busy", busy, 1);
    chk("g_fail", fail_cnt, 1);
    chk("g_pass", pass_cnt, 0);
    chk("g_pops", pops - base, 1);
    tick(0, 1);
    tick();
    #3;
    chk("g_done", done, 1);
    flush();
`endif

    tick();
    tick();
    #3;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
